// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and shared-memory handshake signals of the
// memory port arbiter.
//   slave  : arbiter side. It sees core requests and memory responses, and
//            drives done/rdata, the stalls, the memory strobes and err.
//   master : core + memory side, the mirror image of slave.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // instruction fetch
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  // data access
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  // hazard unit
  logic          stall_f;
  logic          stall_m;
  // shared memory port
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          err;

  modport slave (
    input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata,
           mem_rdata, mem_ready,
    output if_done, if_rdata, dm_done, dm_rdata, stall_f, stall_m,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata,
           mem_rdata, mem_ready,
    input  if_done, if_rdata, dm_done, dm_rdata, stall_f, stall_m,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and data (DM).
// Data normally wins. After MAX_DM_BURST data grants in a row that each
// starved a waiting fetch, the fetch is granted once. Every access takes at
// least 2 cycles: a grant edge, then a completion edge. An access that sees
// no mem_ready within TIMEOUT busy cycles completes anyway. It then returns
// a NOP (fetch) or 0 (data) and sets the sticky err flag.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous, active-low reset
//   bus - mem_port_arbiter_if.slave, carrying the fetch/data handshakes,
//         the stalls, the shared memory port and err
module mem_port_arbiter #(
  parameter int          AW           = 32,
  parameter int          DW           = 32,
  parameter int          MAX_DM_BURST = 4,
  parameter int          TIMEOUT      = 15,
  parameter logic [DW-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int BW = $clog2(MAX_DM_BURST + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_DM_BURST);
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [WW-1:0] wait_q, wait_d, wait_inc;
  logic          flush_q, flush_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          if_done_q, if_done_d, dm_done_q, dm_done_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic          err_q, err_d;
  logic          if_ok, dm_win, tmo, if_kill;

  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    wait_d     = wait_q;
    flush_d    = flush_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    err_d      = err_q;
    // a fetch raised together with a flush is already stale
    if_ok    = bus.if_req & ~bus.if_flush;
    dm_win   = bus.dm_req & ~(if_ok & (burst_q == BMAX));
    wait_inc = wait_q + 1'b1;
    // ready on the timeout cycle is a normal completion
    tmo      = ~bus.mem_ready & (wait_inc == WMAX);
    // a flush seen at any point of the fetch, including its last cycle,
    // discards the result
    if_kill  = flush_q | bus.if_flush;

    unique case (state_q)
      IDLE: begin
        wait_d  = '0;
        flush_d = 1'b0;
        if (dm_win) begin
          state_d = BUSY_DM;
          addr_d  = bus.dm_addr;
          we_d    = bus.dm_we;
          wdata_d = bus.dm_wdata;
          // only grants that make a fetch wait count towards the burst
          if (bus.if_req) burst_d = (burst_q == BMAX) ? burst_q : burst_q + 1'b1;
          else            burst_d = '0;
        end else if (if_ok) begin
          state_d = BUSY_IF;
          addr_d  = bus.if_addr;
          we_d    = 1'b0;
          wdata_d = '0;
          burst_d = '0;
        end
      end
      BUSY_IF: begin
        flush_d = if_kill;
        if (bus.mem_ready || tmo) begin
          state_d = IDLE;
          if (tmo) err_d = 1'b1;
          if (!if_kill) begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.mem_ready ? bus.mem_rdata : NOP_INSTR;
          end
        end else begin
          wait_d = wait_inc;
        end
      end
      BUSY_DM: begin
        if (bus.mem_ready || tmo) begin
          state_d    = IDLE;
          dm_done_d  = 1'b1;
          dm_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
          if (tmo) err_d = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      burst_q    <= '0;
      wait_q     <= '0;
      flush_q    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      wait_q     <= wait_d;
      flush_q    <= flush_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.mem_req   = (state_q != IDLE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  // we_q survives the access, so qualify it to keep the strobe clean
  assign bus.mem_we    = we_q & (state_q == BUSY_DM);
  assign bus.if_done   = if_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.err       = err_q;
  assign bus.stall_f   = bus.if_req & ~if_done_q & ~bus.if_flush;
  assign bus.stall_m   = bus.dm_req & ~dm_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs are driven and outputs are
// sampled 1ns after each rising edge.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(
    .AW(32), .DW(32), .MAX_DM_BURST(4), .TIMEOUT(15), .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.if_flush  = 1'b0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    logic isd;
    idle_inputs();
    rst = 1'b0;
    tick(2);
    chk("rst_mem_req",  bus.mem_req,  0);
    chk("rst_if_done",  bus.if_done,  0);
    chk("rst_err",      bus.err,      0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    rst = 1'b1;
    tick();

    // single fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
    #1 chk("f_stall_f", bus.stall_f, 1);
    tick();
    chk("f_mem_req",  bus.mem_req,  1);
    chk("f_mem_addr", bus.mem_addr, 32'h100);
    chk("f_mem_we",   bus.mem_we,   0);
    chk("f_done_early", bus.if_done, 0);
    tick();
    chk("f_if_done",  bus.if_done,  1);
    chk("f_if_rdata", bus.if_rdata, 32'hCAFE_0001);
    chk("f_req_off",  bus.mem_req,  0);
    chk("f_stall_f_done", bus.stall_f, 0);
    bus.if_req = 1'b0;
    tick();
    chk("f_done_pulse", bus.if_done, 0);
    chk("f_no_regrant", bus.mem_req, 0);

    // contention: D D D D I D D D D I
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1;
    bus.dm_addr = 32'h2000; bus.dm_wdata = 32'hDEAD_BEEF;
    for (int g = 0; g < 10; g++) begin
      isd = ((g % 5) != 4);
      tick();
      chk($sformatf("c%0d_mem_req", g), bus.mem_req, 1);
      chk($sformatf("c%0d_addr", g), bus.mem_addr, isd ? 32'h2000 : 32'h200);
      chk($sformatf("c%0d_we", g), bus.mem_we, isd);
      tick();
      chk($sformatf("c%0d_dm_done", g), bus.dm_done, isd);
      chk($sformatf("c%0d_if_done", g), bus.if_done, !isd);
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    tick();
    chk("c_idle", bus.mem_req, 0);

    // fetch with flush in the same cycle is not granted
    bus.mem_ready = 1'b0;
    bus.if_req = 1'b1; bus.if_flush = 1'b1;
    #1 chk("nf_stall_f", bus.stall_f, 0);
    tick();
    chk("nf_no_grant", bus.mem_req, 0);
    bus.if_flush = 1'b0;

    // flush during BUSY_IF
    bus.if_addr = 32'h300;
    tick();
    chk("fl_busy", bus.mem_req, 1);
    bus.if_flush = 1'b1;
    tick();
    bus.if_flush = 1'b0; bus.if_req = 1'b0;
    tick(2);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_1111;
    tick();
    chk("fl_no_done", bus.if_done,  0);
    chk("fl_idle",    bus.mem_req,  0);
    chk("fl_rdata",   bus.if_rdata, 32'hCAFE_0001);
    bus.mem_ready = 1'b0;
    tick();

    // data load timeout, then fetch timeout
    bus.dm_req = 1'b1; bus.dm_addr = 32'h40;
    tick();
    tick(14);
    chk("tdm_busy15", bus.mem_req, 1);
    chk("tdm_nodone", bus.dm_done, 0);
    chk("tdm_err0",   bus.err,     0);
    tick();
    chk("tdm_done",  bus.dm_done,  1);
    chk("tdm_rdata", bus.dm_rdata, 0);
    chk("tdm_err",   bus.err,      1);
    chk("tdm_idle",  bus.mem_req,  0);
    bus.dm_req = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    tick();
    tick(14);
    chk("tif_nodone", bus.if_done, 0);
    tick();
    chk("tif_done",  bus.if_done,  1);
    chk("tif_nop",   bus.if_rdata, 32'h0000_0013);
    bus.if_req = 1'b0;
    tick();
    chk("tif_err_sticky", bus.err, 1);

    // reset clears err
    rst = 1'b0;
    tick();
    chk("rst2_err", bus.err, 0);
    rst = 1'b1;
    tick();

    // mem_ready on the 15th busy cycle wins over the timeout
    bus.dm_req = 1'b1; bus.dm_addr = 32'h60;
    tick();
    tick(14);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
    tick();
    chk("tie_done",  bus.dm_done,  1);
    chk("tie_rdata", bus.dm_rdata, 32'h1234_5678);
    chk("tie_err",   bus.err,      0);
    bus.dm_req = 1'b0; bus.mem_ready = 1'b0;
    tick();

    // reset during BUSY_DM
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h70; bus.dm_wdata = 32'h55;
    tick();
    chk("rm_busy", bus.mem_req, 1);
    chk("rm_we",   bus.mem_we,  1);
    rst = 1'b0;
    tick();
    chk("rm_req",   bus.mem_req,   0);
    chk("rm_done",  bus.dm_done,   0);
    chk("rm_addr",  bus.mem_addr,  0);
    chk("rm_we0",   bus.mem_we,    0);
    chk("rm_wdata", bus.mem_wdata, 0);
    chk("rm_rdata", bus.dm_rdata,  0);
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    rst = 1'b1;
    tick();
    chk("rm_after_req",  bus.mem_req, 0);
    chk("rm_after_done", bus.dm_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
